// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
// Shared constants and types for the 80-bit ripple-carry adder result path.
//   WORD_W    : width of one output word (one 16-bit RCA slice)
//   NUM_WORDS : words per 80-bit result
//   SUM_W     : full adder result width
//   IDX_W     : width of the word index bus
//   state_t   : serializer FSM states (IDLE = empty, SEND = holding a result)
// ---------------------------------------------------------------------------
package rca_pkg;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 5;
    localparam int SUM_W     = 80;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rca80_result_serializer.sv
// ---------------------------------------------------------------------------
// rca80_result_serializer
// Captures one 80-bit adder result (sum + carry out) and streams it downstream
// as NUM_WORDS words of WORD_W bits, least-significant word first, with a
// valid/ready handshake on both sides.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : upstream result valid
//   in_ready   : serializer can capture a result this cycle
//   S          : 80-bit sum from the adder
//   Cout       : carry out from the adder
//   out_valid  : out_data holds a valid word
//   out_ready  : downstream accepts the word
//   out_data   : current sum word
//   out_idx    : index of the current word (0..NUM_WORDS-1)
//   out_last   : high on the final word only
//   out_cout   : captured carry, shown on the final word only
// ---------------------------------------------------------------------------
module rca80_result_serializer #(
    parameter int WORD_W    = rca_pkg::WORD_W,
    parameter int NUM_WORDS = rca_pkg::NUM_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [rca_pkg::SUM_W-1:0]  S,
    input  logic                       Cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic [rca_pkg::IDX_W-1:0]  out_idx,
    output logic                       out_last,
    output logic                       out_cout
);

    import rca_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [SUM_W-1:0]   r_data;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic               w_isLast;
    logic               w_inReady;
    logic               w_outValid;
    logic               w_capture;
    logic               w_beat;
    logic [WORD_W-1:0]  w_word;

    assign w_isLast  = (r_idx == LAST_IDX);
    assign w_capture = in_valid & w_inReady;
    assign w_beat    = w_outValid & out_ready;

    // Select the current word by shifting the captured result down.
    assign w_word = WORD_W'(r_data >> (int'(r_idx) * WORD_W));

    // Handshake outputs and next state. Everything is forced low while reset
    // is asserted, since the reset is synchronous and the state register may
    // still hold a live result until the next edge. While sending, a new
    // result may be accepted only on the final beat, which lets results flow
    // back-to-back without a bubble.
    always_comb begin
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (in_valid) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                w_outValid = 1'b1;
                w_inReady  = w_isLast & out_ready;
                if (w_isLast && out_ready && !in_valid) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (!rst_n) begin
            w_inReady  = 1'b0;
            w_outValid = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture register and word index. A capture always restarts at word 0,
    // which also covers a capture coinciding with the last beat. The index
    // returns to 0 after the last beat so it can never run past the final word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cout <= 1'b0;
            r_idx  <= '0;
        end else if (w_capture) begin
            r_data <= S;
            r_cout <= Cout;
            r_idx  <= '0;
        end else if (w_beat) begin
            r_idx <= w_isLast ? '0 : r_idx + 1'b1;
        end
    end

    // Word outputs are zero whenever no word is being offered.
    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_data  = w_outValid ? w_word : '0;
    assign out_idx   = w_outValid ? r_idx : '0;
    assign out_last  = w_outValid & w_isLast;
    assign out_cout  = w_outValid & w_isLast & r_cout;

endmodule

// File: tb/tb_rca80_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_rca80_result_serializer
// Directed bench for the 80-bit result serializer: reset values, a basic
// five-word transfer, an output stall with input backpressure, a
// back-to-back capture on the last beat, and a reset in mid-transfer.
// ---------------------------------------------------------------------------
module tb_rca80_result_serializer;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [79:0]  sumIn;
    logic         coutIn;
    logic         outValid;
    logic         outReady;
    logic [15:0]  outData;
    logic [2:0]   outIdx;
    logic         outLast;
    logic         outCout;

    int total = 0;
    int bad   = 0;

    localparam logic [79:0] SUM_A = 80'h0004_0003_0002_0001_0000;
    localparam logic [79:0] SUM_B = {80{1'b1}};

    rca80_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .S         (sumIn),
        .Cout      (coutIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_idx   (outIdx),
        .out_last  (outLast),
        .out_cout  (outCout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full word-side output bundle.
    task automatic checkWord(input string tag, input logic [15:0] data, input logic [2:0] idx,
                             input logic last, input logic cout, input logic rdy);
        checkOutput({tag, ".valid"}, 80'(outValid), 80'(1));
        checkOutput({tag, ".data"},  80'(outData),  80'(data));
        checkOutput({tag, ".idx"},   80'(outIdx),   80'(idx));
        checkOutput({tag, ".last"},  80'(outLast),  80'(last));
        checkOutput({tag, ".cout"},  80'(outCout),  80'(cout));
        checkOutput({tag, ".inrdy"}, 80'(inReady),  80'(rdy));
    endtask

    initial begin
        $display("[TB] start");
        rst_n    = 1'b0;
        inValid  = 1'b0;
        sumIn    = '0;
        coutIn   = 1'b0;
        outReady = 1'b0;

        // Reset values, including a request held during reset.
        applyStimulus();
        inValid = 1'b1;
        sumIn   = SUM_A;
        coutIn  = 1'b1;
        applyStimulus();
        checkOutput("rst.valid", 80'(outValid), 80'(0));
        checkOutput("rst.inrdy", 80'(inReady),  80'(0));
        checkOutput("rst.data",  80'(outData),  80'(0));
        checkOutput("rst.idx",   80'(outIdx),   80'(0));
        checkOutput("rst.last",  80'(outLast),  80'(0));
        checkOutput("rst.cout",  80'(outCout),  80'(0));

        // First cycle after release: ready, nothing on output.
        inValid = 1'b0;
        rst_n   = 1'b1;
        #1;
        checkOutput("rel.inrdy", 80'(inReady),  80'(1));
        checkOutput("rel.valid", 80'(outValid), 80'(0));

        // Basic five-word transfer.
        $display("[TB] basic transfer");
        inValid  = 1'b1;
        sumIn    = SUM_A;
        coutIn   = 1'b1;
        outReady = 1'b1;
        applyStimulus();
        inValid = 1'b0;
        sumIn   = '0;
        coutIn  = 1'b0;
        checkWord("basic0", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            applyStimulus();
            checkWord("basic", 16'(k), 3'(k), k == 4, k == 4, k == 4);
        end
        applyStimulus();
        checkOutput("basic.idle.valid", 80'(outValid), 80'(0));
        checkOutput("basic.idle.inrdy", 80'(inReady),  80'(1));

        // Stall at word 2 while upstream holds a new result.
        $display("[TB] stall and input backpressure");
        inValid = 1'b1;
        sumIn   = SUM_A;
        coutIn  = 1'b1;
        applyStimulus();
        inValid = 1'b0;
        checkWord("stall0", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkWord("stall1", 16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkWord("stall2", 16'h0002, 3'd2, 1'b0, 1'b0, 1'b0);
        outReady = 1'b0;
        inValid  = 1'b1;
        sumIn    = SUM_B;
        coutIn   = 1'b0;
        checkOutput("stall2.inrdy.held", 80'(inReady), 80'(0));
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkWord("stallhold", 16'h0002, 3'd2, 1'b0, 1'b0, 1'b0);
        end
        outReady = 1'b1;
        applyStimulus();
        checkWord("resume3", 16'h0003, 3'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkWord("resume4", 16'h0004, 3'd4, 1'b1, 1'b1, 1'b1);

        // Back-to-back: SUM_B captured on the last beat of SUM_A.
        $display("[TB] back-to-back");
        applyStimulus();
        inValid = 1'b0;
        sumIn   = '0;
        checkWord("b2b0", 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            applyStimulus();
            checkWord("b2b", 16'hFFFF, 3'(k), k == 4, 1'b0, k == 4);
        end
        applyStimulus();
        checkOutput("b2b.idle.valid", 80'(outValid), 80'(0));

        // Reset while word 3 is on the output.
        $display("[TB] reset mid-transfer");
        inValid = 1'b1;
        sumIn   = SUM_A;
        coutIn  = 1'b1;
        applyStimulus();
        inValid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            applyStimulus();
        end
        checkWord("pre.rst3", 16'h0003, 3'd3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.comb.valid", 80'(outValid), 80'(0));
        applyStimulus();
        checkOutput("midrst.valid", 80'(outValid), 80'(0));
        checkOutput("midrst.data",  80'(outData),  80'(0));
        checkOutput("midrst.inrdy", 80'(inReady),  80'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("postrst.inrdy", 80'(inReady), 80'(1));
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput("postrst.valid", 80'(outValid), 80'(0));
            checkOutput("postrst.data",  80'(outData),  80'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
